// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if
//   Bundles the two-master upstream read ports (m_*, packed, master 0 in the
//   LSBs) and the single downstream slave read port (s_*) of axi_rd_arbiter.
//   Modports:
//     arb    : the arbiter's view (consumes m_ar*/m_rready/s_r*, drives the rest)
//     master : the upstream masters' view (drive m_ar*/m_rready)
//     slave  : the downstream slave's view (drives s_arready/s_r*)
interface axi_rd_arbiter_if #(
  parameter int unsigned addr_width   = 4,
  parameter int unsigned data_width   = 32,
  parameter int unsigned len          = 4,
  parameter int unsigned burst_length = 2,
  parameter int unsigned resp         = 2
);
  localparam int unsigned NM = 2;

  // Upstream (per-master, packed)
  logic [2*NM-1:0]            m_arid;
  logic [addr_width*NM-1:0]   m_araddr;
  logic [len*NM-1:0]          m_arlen;
  logic [burst_length*NM-1:0] m_arburst;
  logic [NM-1:0]              m_arvalid;
  logic [NM-1:0]              m_arready;
  logic [data_width*NM-1:0]   m_rdata;
  logic [resp*NM-1:0]         m_rresp;
  logic [NM-1:0]              m_rlast;
  logic [NM-1:0]              m_rvalid;
  logic [NM-1:0]              m_rready;

  // Downstream slave
  logic [1:0]                 s_arid;
  logic [addr_width-1:0]      s_araddr;
  logic [len-1:0]             s_arlen;
  logic [burst_length-1:0]    s_arburst;
  logic                       s_arvalid;
  logic                       s_arready;
  logic [data_width-1:0]      s_rdata;
  logic [resp-1:0]            s_rresp;
  logic                       s_rlast;
  logic                       s_rvalid;
  logic                       s_rready;

  modport arb (
    input  m_arid, m_araddr, m_arlen, m_arburst, m_arvalid, m_rready,
    input  s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    output s_arid, s_araddr, s_arlen, s_arburst, s_arvalid, s_rready
  );

  modport master (
    output m_arid, m_araddr, m_arlen, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arburst, s_arvalid, s_rready,
    output s_arready, s_rdata, s_rresp, s_rlast, s_rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Two-master AXI read-channel arbiter in front of a single slave read port.
//   One master is granted for a whole burst: its AR request is forwarded,
//   the returning R beats are routed to it only, and the grant is released on
//   the beat carrying rlast or on the (arlen+1)-th beat, whichever is first.
//   Ports:
//     aclk    : clock
//     aresetn : synchronous active-low reset
//     bus     : axi_rd_arbiter_if.arb (m_* master side, s_* slave side)
//     grant   : one-hot registered grant, 0 when idle
//     busy    : high while in ADDR or DATA
//   Build option:
//     ARB_RR_EN defined   -> round-robin tie-break (alternates on ties)
//     ARB_RR_EN undefined -> fixed priority, master 0 wins ties
module axi_rd_arbiter #(
  parameter int unsigned NM           = 2,
  parameter int unsigned addr_width   = 4,
  parameter int unsigned data_width   = 32,
  parameter int unsigned len          = 4,
  parameter int unsigned burst_length = 2,
  parameter int unsigned resp         = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_rd_arbiter_if.arb     bus,
  output logic [NM-1:0]     grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic            last_q, last_d;
  logic [len-1:0]  len_q, len_d;
  logic [len-1:0]  beat_q, beat_d;

  logic            g;          // index of the granted master
  logic            tie_pick;
  logic            pick;
  logic [len-1:0]  sel_arlen;

  logic            arvalid_c;
  logic [NM-1:0]   arready_c;
  logic [NM-1:0]   rvalid_c;
  logic [NM-1:0]   rlast_c;
  logic            rready_c;

  assign g = grant_q[1];

`ifdef ARB_RR_EN
  assign tie_pick = ~last_q;
`else
  // last_grant is still tracked, but masked out so master 0 always wins ties.
  assign tie_pick = last_q & 1'b0;
`endif

  // A lone requester always wins; only a tie consults tie_pick.
  assign pick = (bus.m_arvalid == 2'b11) ? tie_pick : bus.m_arvalid[1];

  // Granted master's AR fields
  assign bus.s_arid    = g ? bus.m_arid[3:2] : bus.m_arid[1:0];
  assign bus.s_araddr  = g ? bus.m_araddr[2*addr_width-1:addr_width]
                           : bus.m_araddr[addr_width-1:0];
  assign sel_arlen     = g ? bus.m_arlen[2*len-1:len] : bus.m_arlen[len-1:0];
  assign bus.s_arlen   = sel_arlen;
  assign bus.s_arburst = g ? bus.m_arburst[2*burst_length-1:burst_length]
                           : bus.m_arburst[burst_length-1:0];

  // Read data/response are broadcast; only rvalid/rlast are steered.
  assign bus.m_rdata = {2{bus.s_rdata}};
  assign bus.m_rresp = {2{bus.s_rresp}};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    len_d     = len_q;
    beat_d    = beat_q;
    arvalid_c = 1'b0;
    arready_c = '0;
    rvalid_c  = '0;
    rlast_c   = '0;
    rready_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.m_arvalid) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = ADDR;
        end
      end

      ADDR: begin
        // If the granted master withdraws arvalid, we simply wait here.
        arvalid_c    = bus.m_arvalid[g];
        arready_c[g] = bus.s_arready;
        if (bus.m_arvalid[g] && bus.s_arready) begin
          len_d   = sel_arlen;
          beat_d  = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        rvalid_c[g] = bus.s_rvalid;
        rlast_c[g]  = bus.s_rlast;
        rready_c    = bus.m_rready[g];
        if (bus.s_rvalid && bus.m_rready[g]) begin
          beat_d = beat_q + 1'b1;
          // Beat count bounds the burst for slaves that never raise rlast.
          if (bus.s_rlast || (beat_q == len_q)) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = g;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are forced low for the whole reset cycle.
  assign bus.s_arvalid = aresetn & arvalid_c;
  assign bus.m_arready = {2{aresetn}} & arready_c;
  assign bus.m_rvalid  = {2{aresetn}} & rvalid_c;
  assign bus.m_rlast   = {2{aresetn}} & rlast_c;
  assign bus.s_rready  = aresetn & rready_c;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
//   Directed bench for axi_rd_arbiter. Stimulus pushes expected AR requests
//   and R beats into queues; a negedge monitor pops and compares whenever the
//   DUT hands an AR to the slave or a beat to a master.
module tb_axi_rd_arbiter;

  logic       clk;
  logic       rstn;
  logic [1:0] grant;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int mdl_last = 1;

  typedef struct {
    int         m;
    logic [1:0] id;
    logic [3:0] addr;
    logic [3:0] len;
    logic [1:0] burst;
  } ar_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic [1:0]  rsp;
    logic        last;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];

  axi_rd_arbiter_if #(
    .addr_width(4), .data_width(32), .len(4), .burst_length(2), .resp(2)
  ) bus ();

  axi_rd_arbiter #(
    .NM(2), .addr_width(4), .data_width(32), .len(4), .burst_length(2), .resp(2)
  ) dut (
    .aclk   (clk),
    .aresetn(rstn),
    .bus    (bus),
    .grant  (grant),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int m);
    return (m == 1) ? 2'b10 : 2'b01;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.s_arvalid && bus.s_arready) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", {bus.s_arid, bus.s_araddr}, 64'hFFFF);
        end else begin
          ar_t e;
          e = ar_q.pop_front();
          chk("ar_grant",   grant,         oh(e.m));
          chk("ar_mready",  bus.m_arready, oh(e.m));
          chk("ar_id",      bus.s_arid,    e.id);
          chk("ar_addr",    bus.s_araddr,  e.addr);
          chk("ar_len",     bus.s_arlen,   e.len);
          chk("ar_burst",   bus.s_arburst, e.burst);
        end
      end
      if (|bus.m_rvalid)
        chk("rvalid_granted_only", bus.m_rvalid & ~grant, 0);
      for (int i = 0; i < 2; i++) begin
        if (bus.m_rvalid[i] && bus.m_rready[i]) begin
          if (r_q.size() == 0) begin
            chk("r_unexpected", bus.m_rdata[i*32 +: 32], 64'hFFFF_FFFF_FFFF);
          end else begin
            r_t e;
            e = r_q.pop_front();
            chk("r_master", i,                       e.m);
            chk("r_data",   bus.m_rdata[i*32 +: 32], e.data);
            chk("r_resp",   bus.m_rresp[i*2 +: 2],   e.rsp);
            chk("r_last",   bus.m_rlast[i],          e.last);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn          = 1'b0;
    bus.m_arvalid = '0;
    bus.s_rvalid  = 1'b0;
    bus.s_rlast   = 1'b0;
    bus.s_arready = 1'b1;
    bus.m_rready  = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rstn     = 1'b1;
    mdl_last = 1;
  endtask

  task automatic raise(input int m, input logic [1:0] id, input logic [3:0] addr,
                       input logic [3:0] ln, input logic [1:0] bt);
    bus.m_arid[m*2 +: 2]    = id;
    bus.m_araddr[m*4 +: 4]  = addr;
    bus.m_arlen[m*4 +: 4]   = ln;
    bus.m_arburst[m*2 +: 2] = bt;
    bus.m_arvalid[m]        = 1'b1;
  endtask

  task automatic expect_ar(input int m, input logic [1:0] id, input logic [3:0] addr,
                           input logic [3:0] ln, input logic [1:0] bt);
    ar_q.push_back('{m: m, id: id, addr: addr, len: ln, burst: bt});
  endtask

  // Waits (bounded) for m_arready[m]; n = negedges waited (0 on timeout).
  task automatic wait_ar(input int m, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.m_arready[m]) begin
        n = i;
        break;
      end
    end
    chk("ar_handshake_seen", (n != 0), 1);
    sync();
    bus.m_arvalid[m] = 1'b0;
  endtask

  // Slave returns nb beats; rlast on beat index last_at (-1: never);
  // m_rready[m] held low 3 cycles while beat stall_at is offered.
  task automatic serve(input int m, input int nb, input int last_at,
                       input int stall_at, input logic [31:0] base);
    int ok;
    for (int k = 0; k < nb; k++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = base + k;
      bus.s_rresp  = k[1:0];
      bus.s_rlast  = (k == last_at);
      r_q.push_back('{m: m, data: base + k, rsp: k[1:0], last: (k == last_at)});
      if (k == stall_at) begin
        bus.m_rready[m] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_s_rready", bus.s_rready, 0);
        end
        sync();
        bus.m_rready[m] = 1'b1;
      end
      ok = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (bus.s_rready) begin
          ok = 1;
          break;
        end
      end
      chk("beat_accepted", ok, 1);
      sync();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
  endtask

  // A beat offered outside a burst must be neither accepted nor forwarded.
  task automatic stray(input int cycles);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'hDEAD_BEEF;
    bus.s_rlast  = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      chk("stray_s_rready", bus.s_rready, 0);
      chk("stray_m_rvalid", bus.m_rvalid, 0);
    end
    sync();
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    chk({name, "_grant"}, grant, 0);
    chk({name, "_busy"},  busy,  0);
  endtask

  initial begin
    int n;
    int w;
    bus.m_arid    = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arburst = '0;
    bus.s_rdata   = '0;
    bus.s_rresp   = '0;

    // Reset state
    reset_dut();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant",     grant,         0);
    chk("rst_busy",      busy,          0);
    chk("rst_s_arvalid", bus.s_arvalid, 0);
    chk("rst_s_rready",  bus.s_rready,  0);
    chk("rst_m_arready", bus.m_arready, 0);
    chk("rst_m_rvalid",  bus.m_rvalid,  0);
    chk("rst_m_rlast",   bus.m_rlast,   0);
    sync();
    rstn = 1'b1;
    idle_check("post_rst");

    // m0 incr burst, 4 beats with rlast on the 4th
    sync();
    raise(0, 2'd2, 4'd1, 4'd3, 2'b01);
    expect_ar(0, 2'd2, 4'd1, 4'd3, 2'b01);
    wait_ar(0, n);
    chk("t1_ar_latency", n, 2);
    serve(0, 4, 3, -1, 32'hA000_0000);
    mdl_last = 0;
    idle_check("t1_end");

    // Four simultaneous-request rounds
    reset_dut();
    for (int r = 0; r < 4; r++) begin
      if (!bus.m_arvalid[0]) raise(0, 2'd0, 4'd2, 4'd1, 2'b01);
      if (!bus.m_arvalid[1]) raise(1, 2'd1, 4'd3, 4'd1, 2'b01);
`ifdef ARB_RR_EN
      w = 1 - mdl_last;
`else
      w = 0;
`endif
      expect_ar(w, 2'(w), (w == 1) ? 4'd3 : 4'd2, 4'd1, 2'b01);
      wait_ar(w, n);
      serve(w, 2, 1, -1, 32'hB000_0000 + 32'(r * 16));
      mdl_last = w;
    end
    bus.m_arvalid = '0;
    idle_check("t2_end");

    // No rlast from slave, arlen=2: burst ends on the 3rd beat
    sync();
    raise(0, 2'd1, 4'd5, 4'd2, 2'b01);
    expect_ar(0, 2'd1, 4'd5, 4'd2, 2'b01);
    wait_ar(0, n);
    serve(0, 3, -1, -1, 32'hC000_0000);
    mdl_last = 0;
    stray(3);
    idle_check("t3_end");

    // m1 burst with rready stalled 3 cycles on beat 2
    sync();
    raise(1, 2'd2, 4'd6, 4'd3, 2'b01);
    expect_ar(1, 2'd2, 4'd6, 4'd3, 2'b01);
    wait_ar(1, n);
    serve(1, 4, 3, 1, 32'hD000_0000);
    mdl_last = 1;
    idle_check("t4_end");

    // Reset during beat 2 of a wrap burst
    sync();
    raise(0, 2'd3, 4'd1, 4'd6, 2'b10);
    expect_ar(0, 2'd3, 4'd1, 4'd6, 2'b10);
    wait_ar(0, n);
    serve(0, 1, -1, -1, 32'hE000_0000);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'hE000_0001;
    rstn         = 1'b0;
    @(negedge clk);
    chk("t5_rst_m_rvalid", bus.m_rvalid, 0);
    chk("t5_rst_s_rready", bus.s_rready, 0);
    sync();
    rstn         = 1'b1;
    bus.s_rvalid = 1'b0;
    mdl_last     = 1;
    @(negedge clk);
    chk("t5_grant",     grant,         0);
    chk("t5_busy",      busy,          0);
    chk("t5_s_arvalid", bus.s_arvalid, 0);
    chk("t5_m_rvalid",  bus.m_rvalid,  0);
    chk("t5_s_rready",  bus.s_rready,  0);

    // m1 arlen=0 with s_arready held off for 2 ADDR cycles
    sync();
    bus.s_arready = 1'b0;
    raise(1, 2'd1, 4'd9, 4'd0, 2'b01);
    expect_ar(1, 2'd1, 4'd9, 4'd0, 2'b01);
    @(negedge clk);
    chk("t6_idle_s_arvalid", bus.s_arvalid, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_wait_s_arvalid", bus.s_arvalid, 1);
      chk("t6_wait_m_arready", bus.m_arready, 0);
    end
    sync();
    bus.s_arready = 1'b1;
    wait_ar(1, n);
    chk("t6_handshake_cycle", n, 1);
    serve(1, 1, -1, -1, 32'hF000_0000);
    stray(2);
    idle_check("t6_end");

    chk("ar_queue_drained", ar_q.size(), 0);
    chk("r_queue_drained",  r_q.size(),  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
